// File: rtl/cdb_broadcaster_pkg.sv
// Shared CDB definitions: default sizing and the broadcast packet seen by the ROB and
// reservation stations.
package cdb_broadcaster_pkg;

  localparam int CDB_NUM_FU       = 4;
  localparam int CDB_FIFO_DEPTH   = 2;
  localparam int CDB_ROB_ADDR_LEN = 5;
  localparam int CDB_XLEN         = 32;

  typedef struct packed {
    logic                        valid;
    logic [CDB_ROB_ADDR_LEN-1:0] rob_tag;
    logic [CDB_XLEN-1:0]         result;
  } cdb_packet_t;

  // Wraps an index that may exceed n by less than n back into 0..n-1.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/cdb_broadcaster_if.sv
// Bundle of FU result inputs, FU back-pressure, flush and the CDB broadcast outputs.
interface cdb_broadcaster_if #(
  parameter int NUM_FU       = cdb_broadcaster_pkg::CDB_NUM_FU,
  parameter int ROB_ADDR_LEN = cdb_broadcaster_pkg::CDB_ROB_ADDR_LEN,
  parameter int XLEN         = cdb_broadcaster_pkg::CDB_XLEN
);

  logic [NUM_FU-1:0]                   fu_valid;
  logic [NUM_FU-1:0][ROB_ADDR_LEN-1:0] fu_tag;
  logic [NUM_FU-1:0][XLEN-1:0]         fu_result;
  logic [NUM_FU-1:0]                   fu_ready;
  logic                                flush;
  logic                                cdb_to_rob;
  logic [ROB_ADDR_LEN-1:0]             rob_tag_from_cdb;
  logic [XLEN-1:0]                     cdb_result;

  // The FUs/ROB side drives results and flush; the broadcaster drives ready and the CDB.
  modport master (
    output fu_valid, fu_tag, fu_result, flush,
    input  fu_ready, cdb_to_rob, rob_tag_from_cdb, cdb_result
  );

  modport slave (
    input  fu_valid, fu_tag, fu_result, flush,
    output fu_ready, cdb_to_rob, rob_tag_from_cdb, cdb_result
  );

endinterface

// File: rtl/cdb_fu_fifo.sv
// Small per-FU result queue with synchronous active-low reset and flush; push is ignored
// when full and pop is ignored when empty.
module cdb_fu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmitter: queues FU results per unit and broadcasts one {tag, result} per cycle
// to the ROB and reservation stations through a round-robin arbiter.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int NUM_FU       = CDB_NUM_FU,
  parameter int FIFO_DEPTH   = CDB_FIFO_DEPTH,
  parameter int ROB_ADDR_LEN = CDB_ROB_ADDR_LEN,
  parameter int XLEN         = CDB_XLEN
) (
  input logic              clk,
  input logic              reset,
  cdb_broadcaster_if.slave bus
);

  localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [ROB_ADDR_LEN-1:0] rob_tag;
    logic [XLEN-1:0]         result;
  } entry_t;

  logic [NUM_FU-1:0]       push;
  logic [NUM_FU-1:0]       pop;
  logic [NUM_FU-1:0]       full;
  logic [NUM_FU-1:0]       empty;
  logic [CW-1:0]           fifo_count [NUM_FU];
  entry_t                  head       [NUM_FU];
  logic [IW-1:0]           scan_idx   [NUM_FU];
  logic [IW-1:0]           rr_ptr;
  logic [IW-1:0]           grant_idx;
  logic                    grant_valid;
  logic                    cdb_valid_q;
  logic [ROB_ADDR_LEN-1:0] cdb_tag_q;
  logic [XLEN-1:0]         cdb_result_q;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign push[i]         = bus.fu_valid[i] && !full[i];
    assign pop[i]          = grant_valid && (grant_idx == IW'(i));
    // Ready depends only on stored occupancy, never on this cycle's pop or fu_valid.
    assign bus.fu_ready[i] = (fifo_count[i] != DEPTH_CNT);
    assign scan_idx[i]     = IW'(rr_wrap(int'(rr_ptr) + i, NUM_FU));

    cdb_fu_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(entry_t))
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (bus.flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   ({bus.fu_tag[i], bus.fu_result[i]}),
      .dout  (head[i]),
      .count (fifo_count[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // NOTE: every always_comb output gets a default up front so no path can infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (!grant_valid && !empty[scan_idx[k]]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx[k];
      end
    end
  end

  // The ROB never stalls, so a grant is a committed broadcast; tag/data hold when idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr       <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_result_q <= '0;
    end else if (bus.flush) begin
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      cdb_valid_q <= grant_valid;
      if (grant_valid) begin
        rr_ptr       <= IW'(rr_wrap(int'(grant_idx) + 1, NUM_FU));
        cdb_tag_q    <= head[grant_idx].rob_tag;
        cdb_result_q <= head[grant_idx].result;
      end
    end
  end

  assign bus.cdb_to_rob       = cdb_valid_q;
  assign bus.rob_tag_from_cdb = cdb_tag_q;
  assign bus.cdb_result       = cdb_result_q;

endmodule

// File: doc/cdb_broadcaster.md
# cdb_broadcaster

Common-data-bus transmitter feeding the ROB's CDB receive port (`cdb_to_rob`, `rob_tag_from_cdb`, `cdb_result`) and, in parallel, the reservation stations. It collects completed results from `NUM_FU` functional units, queues each in a small per-FU FIFO, and broadcasts one `{rob_tag, result}` per cycle through a round-robin arbiter. The ROB has no back-pressure, so a broadcast is always consumed; back-pressure exists only toward the functional units.

## Interface
Parameters:
- `NUM_FU`, 4: number of functional-unit result sources.
- `FIFO_DEPTH`, 2: entries per FU queue; must be a power of 2 and at least 2.
- `ROB_ADDR_LEN`, `` `ROB_ADDR_LEN ``: tag width.
- `XLEN`, `` `XLEN ``: result width.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; clears state when sampled 0.
- `fu_valid`  in  `[NUM_FU]`  FU i presents a result this cycle.
- `fu_tag`  in  `[NUM_FU][ROB_ADDR_LEN]`  ROB tag of FU i's result.
- `fu_result`  in  `[NUM_FU][XLEN]`  result data of FU i.
- `fu_ready`  out  `[NUM_FU]`  FU i's queue can accept this cycle.
- `flush`  in  1  mispredict flush; discards all queued and in-flight results.
- `cdb_to_rob`  out  1  broadcast valid.
- `rob_tag_from_cdb`  out  `ROB_ADDR_LEN`  broadcast tag.
- `cdb_result`  out  `XLEN`  broadcast data.

## Operation
- **Push.** Queue i is written on an edge where `fu_valid[i] && fu_ready[i]`, `reset` is 1, and `flush` is 0. If `fu_valid[i]` is high while `fu_ready[i]` is low, the FU must hold its result; nothing is dropped.
- **`fu_ready[i]`** is combinational: `count[i] != FIFO_DEPTH`, decided from current state only.
  - A full queue reports not-ready even in a cycle where it is being popped.
  - No combinational path from `fu_valid` to `fu_ready`.
- **Arbitration.** Each cycle, among non-empty queues, grant the first index at or after `rr_ptr`, scanning upward modulo `NUM_FU`.
  - On a grant, pop that queue's head and set `rr_ptr <= grant + 1` (mod `NUM_FU`).
  - With no grant, `rr_ptr` holds.
- **Output register.**
  - On a grant: `cdb_to_rob <= 1`, and the tag and data are loaded from the popped head.
  - With no grant: `cdb_to_rob <= 0`, and the tag and data hold their previous values.
- **Queue bookkeeping.**
  - Simultaneous push and pop on the same queue leaves `count` unchanged; both pointers advance.
  - Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
  - `count` is `$clog2(FIFO_DEPTH)+1` bits.
- **Flush** (edge with `flush`=1, `reset`=1):
  - all counts and pointers go to 0 and `rr_ptr` goes to 0;
  - that cycle's pushes and pop are discarded;
  - `cdb_to_rob <= 0`, and the tag and data hold.
- **Reset** (edge with `reset`=0) takes priority over flush and push. Values after the edge:
  - counts, pointers and `rr_ptr` are 0;
  - `cdb_to_rob`, `rob_tag_from_cdb` and `cdb_result` are 0;
  - `fu_ready` is all-ones.
  - Reset asserted mid-operation drops all queued results.

## Timing
- **Latency.** A result pushed on edge k into an empty queue that wins arbitration appears with `cdb_to_rob`=1 in the cycle following edge k+1, i.e. 2 cycles from presentation.
- **Throughput.** One broadcast per cycle in aggregate; each FU sustains one result per cycle only if it wins every grant.
- **Fairness.** With all queues continuously non-empty, each FU is granted exactly once every `NUM_FU` cycles.
- **Hold time.** A queued result waits at most `NUM_FU-1` grants before its queue head is served.
- **Registered outputs.** Broadcast outputs are registered; `fu_ready` is combinational from state only.

## Structure
- `CDB_PACKET` typedef (`valid`, `rob_tag[ROB_ADDR_LEN]`, `result[XLEN]`) goes in `sys_defs.svh`, so the ROB and reservation stations share it.
- `NUM_FU` and `CDB_FIFO_DEPTH` defaults also go in `sys_defs.svh`.
- Sub-module `cdb_fu_fifo`: one per FU, generated `NUM_FU` times.
  - Ports: `clk`, `reset`, `flush`, `push`, `pop`, `din`, `dout`, `count`, `full`, `empty`.
  - Same reset and flush semantics as the parent.
- Round-robin arbiter stays inline in `cdb_broadcaster` (priority scan from `rr_ptr`).

## Test plan
- **Reset.** Drive `reset`=0 for 2 cycles with `fu_valid`=4'b1111.
  - Expect `cdb_to_rob`=0, tag/data=0, and `fu_ready`=4'b1111 after release.
  - Expect no broadcast afterwards.
- **Single result.** FU2 pushes tag=5, result=32'hDEADBEEF at cycle 10.
  - Expect `cdb_to_rob`=1, tag=5, data=DEADBEEF in cycle 12 only.
- **Contention.** All four FUs push in the same cycle with tags 1..4 and `rr_ptr`=0.
  - Expect broadcasts of tags 1, 2, 3, 4 on consecutive cycles, then `cdb_to_rob`=0.
- **Back-pressure.** FU0 pushes tags 7, 8 while FU1..3 continuously occupy the bus.
  - Expect `fu_ready[0]`=0 once `count`=2 (`FIFO_DEPTH`=2).
  - A held `fu_valid[0]` with tag 9 is accepted only after a pop.
  - Tags 7, 8, 9 broadcast in order; none is lost.
- **Flush.** Load 3 queued results, then assert `flush` for one cycle coincident with a push of tag 12.
  - Expect `cdb_to_rob`=0 for the next cycle.
  - Tag 12 and all queued tags are never broadcast; `fu_ready`=4'b1111.
- **Wrap-around.** Stream 10 results through FU3 alone.
  - Expect tags broadcast in push order, each exactly once, across multiple pointer wraps.
